four_bit_adder: RTL and testbench
=================================

# four_bit_adder

Registered ripple-carry adder: adds two WIDTH-bit operands plus a carry-in and presents the sum and carry-out one clock later with a valid flag. It is built from a chain of single-bit full-adder cells and is the basic arithmetic primitive for datapath blocks that need a clocked, resettable add.

## Interface
- WIDTH, 4, operand/sum width in bits; legal range 1 to 32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  qualifies a, b and cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out (MSB of the WIDTH+1 result).
- out_valid  output  1  sum/cout hold a new result this cycle.
- ovf  output  1  signed overflow flag; present only with FOUR_BIT_ADDER_OVF_EN.

## Operation
- Combinational core: result[WIDTH:0] = a + b + cin, formed by a ripple of WIDTH full-adder cells. The cell at bit i computes s = a^b^c and co = (a&b)|(c&(a^b)). Cell 0 takes cin. Cell i+1 takes the co of cell i. The co of the last cell is cout.
- Arithmetic is exact modulo 2^(WIDTH+1). There is no saturation. Wrap-around shows only in sum; cout carries the lost bit (e.g. 1111+0001 -> cout=1, sum=0000).
- When in_valid=1 at a clock edge, sum and cout load the new result and out_valid is set to 1.
- When in_valid=0 at a clock edge, sum and cout keep their values and out_valid is set to 0.
- Inputs are not otherwise registered. No back-pressure: every valid input produces exactly one output cycle.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Throughput is one add per cycle.
- Reset values: sum=0, cout=0, out_valid=0, and ovf=0 when present.
- Reset has priority over in_valid. If rst=1 and in_valid=1 on the same edge, the input is discarded.
- Reset mid-stream: a result loaded before the reset edge is lost. The first result after reset appears one cycle after the first in_valid with rst=0.
- All outputs are driven directly from flops; there is no combinational path from input to output.
- The ripple depth of WIDTH cells must close timing at the target clock for WIDTH≤32.

## Configuration
- FOUR_BIT_ADDER_OVF_EN defined: adds the output port ovf. It is registered alongside sum, with ovf = (a[MSB]==b[MSB]) && (sum_next[MSB]!=a[MSB]), i.e. two's-complement overflow, where sum_next is the combinational sum being loaded. It updates only when in_valid=1 and resets to 0.
- FOUR_BIT_ADDER_OVF_EN undefined: the ovf port and its flop do not exist. All other behaviour is identical.

## Structure
- Shared package four_bit_adder_pkg holds:
  - the default width constant ADD_WIDTH_DEFAULT = 4;
  - a typedef for a WIDTH+1 result (carry concatenated with sum).
- One sub-module, full_adder: purely combinational, 1-bit ports a, b, cin, sum, cout. The top instantiates WIDTH copies in a generate loop.
- The top level contains the generate chain, the output register, the valid flop and the optional overflow logic.

## Test plan
- Full-adder cell, exhaustive: all 8 combinations of a/b/cin -> {cout,sum} equals the 2-bit count of ones (e.g. 1,1,1 -> 11; 0,1,0 -> 01).
- Top level, WIDTH=4, cin=0, each applied with in_valid=1, results checked on the next cycle with out_valid=1:
  - 0101+1001 -> cout=0, sum=1110;
  - 0110+1001 -> cout=0, sum=1111;
  - 1111+0001 -> cout=1, sum=0000 (wrap).
- Carry-in: 1111+0000 with cin=1 -> cout=1, sum=0000. Then 0000+0000 with cin=1 -> cout=0, sum=0001.
- Valid hold: load 0011+0001 (result 0100), then drop in_valid and change the inputs to 1111+1111 -> sum stays 0100 and out_valid=0 the next cycle.
- Reset: assert rst together with in_valid=1 on 1000+1000 -> the next cycle shows sum=0000, cout=0, out_valid=0. Then release rst and apply 0001+0001 -> sum=0010 one cycle later.
- Overflow (macro defined): 0111+0001 -> sum=1000, ovf=1. Then 1000+1000 -> sum=0000, cout=1, ovf=1. Then 0011+0001 -> ovf=0.

Source files
------------

// File: rtl/four_bit_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package four_bit_adder_pkg;

  localparam int unsigned ADD_WIDTH_DEFAULT = 4;

  // Carry concatenated above the sum bits: {cout, sum}.
  typedef struct packed {
    logic                         cout;
    logic [ADD_WIDTH_DEFAULT-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full-adder cell used as the ripple stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/four_bit_adder.sv
// Registered WIDTH-bit ripple-carry adder with valid flag.
// Optional signed-overflow output enabled by FOUR_BIT_ADDER_OVF_EN.
module four_bit_adder
  import four_bit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FOUR_BIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  // Ripple chain: cell i consumes the carry produced by cell i-1.
  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (w_carry[gi]),
      .sum  (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;

`ifdef FOUR_BIT_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Same-sign operands producing an opposite-sign sum is two's-complement overflow.
  assign w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed test plan plus randomized
// traffic against an arithmetic reference model. Honors FOUR_BIT_ADDER_OVF_EN.
module tb_four_bit_adder;
  import four_bit_adder_pkg::*;

  localparam int unsigned W = ADD_WIDTH_DEFAULT;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
  logic         ovf;
`endif

  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the outputs should show after the last edge.
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_valid;
  logic         m_ovf;

  always #5 clk = ~clk;

  four_bit_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef FOUR_BIT_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  full_adder u_fa_cell (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".sum"},       32'(sum),       32'(m_sum));
    check({tag, ".cout"},      32'(cout),      32'(m_cout));
`ifdef FOUR_BIT_ADDER_OVF_EN
    check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    add_result_t res;
    int sa, sb, sr;
    @(negedge clk);
    rst = r; in_valid = v; a = xa; b = xb; cin = xc;
    @(posedge clk);
    res = add_result_t'(int'(xa) + int'(xb) + int'(xc));
    sa  = xa[W-1] ? int'(xa) - (1 << W) : int'(xa);
    sb  = xb[W-1] ? int'(xb) - (1 << W) : int'(xb);
    sr  = sa + sb + int'(xc);
    if (r) begin
      m_sum = '0; m_cout = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_sum  = res.sum;
        m_cout = res.cout;
        m_ovf  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    m_sum = 'x; m_cout = 1'bx; m_valid = 1'bx; m_ovf = 1'bx;

    // Full-adder cell, exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = 3'(i);
      fa_a = v3[2]; fa_b = v3[1]; fa_cin = v3[0];
      #1;
      check("fa_cell", 32'({fa_cout, fa_sum}), 32'(int'(v3[2]) + int'(v3[1]) + int'(v3[0])));
    end

    step("reset0", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step("reset1", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("reset_sum_zero", 32'(sum), 32'd0);

    step("add_5_9", 1'b0, 1'b1, 4'b0101, 4'b1001, 1'b0);
    check("add_5_9_literal", 32'({cout, sum}), 32'b0_1110);
    step("add_6_9", 1'b0, 1'b1, 4'b0110, 4'b1001, 1'b0);
    check("add_6_9_literal", 32'({cout, sum}), 32'b0_1111);
    step("wrap_15_1", 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
    check("wrap_15_1_literal", 32'({cout, sum}), 32'b1_0000);
    step("cin_15_0", 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    check("cin_15_0_literal", 32'({cout, sum}), 32'b1_0000);
    step("cin_0_0", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
    check("cin_0_0_literal", 32'({cout, sum}), 32'b0_0001);

    step("hold_load", 1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
    step("hold_idle", 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0);
    check("hold_literal", 32'({out_valid, sum}), 32'b0_0100);

    step("rst_vs_valid", 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0);
    check("rst_vs_valid_literal", 32'({out_valid, cout, sum}), 32'b0_0_0000);
    step("post_reset", 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    check("post_reset_literal", 32'({out_valid, sum}), 32'b1_0010);

`ifdef FOUR_BIT_ADDER_OVF_EN
    step("ovf_7_1", 1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    check("ovf_7_1_literal", 32'({ovf, sum}), 32'b1_1000);
    step("ovf_8_8", 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0);
    check("ovf_8_8_literal", 32'({ovf, cout, sum}), 32'b1_1_0000);
    step("ovf_3_1", 1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
    check("ovf_3_1_literal", 32'(ovf), 32'd0);
`endif

    // Randomized traffic with occasional idles and resets.
    for (int n = 0; n < 300; n++) begin
      logic         rr, vv, cc;
      logic [W-1:0] ra, rb;
      rr = ($urandom_range(31) == 0);
      vv = ($urandom_range(3) != 0);
      cc = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      step("random", rr, vv, ra, rb, cc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
